// File: rtl/csr_pkg.sv
// Shared constants and types for the machine-mode CSR file: slot indices,
// mstatus/mip/mie bit positions and the IFU redirect record.
package csr_pkg;

  localparam int CSR_MSTATUS  = 0;
  localparam int CSR_MTVEC    = 1;
  localparam int CSR_MEPC     = 2;
  localparam int CSR_MCAUSE   = 3;
  localparam int CSR_MIE      = 4;
  localparam int CSR_MIP      = 5;
  localparam int CSR_MCYCLE   = 6;
  localparam int CSR_MINSTRET = 7;
  localparam int CSR_FIRST_SCRATCH = 8;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;
  localparam int MIP_MTIP       = 7;
  localparam int MIE_MTIE       = 7;

  localparam int REDIR_PC_W = 64;

  typedef struct packed {
    logic                  valid;
    logic [REDIR_PC_W-1:0] pc;
  } redirect_t;

endpackage

// File: rtl/csr_file_ext_counter.sv
// Wrap-around counter with a load port that takes priority over increment.
module csr_counter #(
  parameter int XLEN = 64
) (
  input  logic            i_clock,
  input  logic            i_rst_n,
  input  logic            i_load,
  input  logic [XLEN-1:0] i_load_val,
  input  logic            i_inc,
  output logic [XLEN-1:0] o_count
);

  logic [XLEN-1:0] r_count;

  // load beats increment; the sum wraps naturally at 2^XLEN
  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_inc) begin
      r_count <= r_count + XLEN'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/csr_file_ext.sv
// Machine-mode CSR file: forwarded read port, one write port, trap entry/mret
// sequencing with a one-cycle IFU redirect, cycle/instret counters, timer irq.
module csr_file_ext
  import csr_pkg::*;
#(
  parameter int              XLEN        = 64,
  parameter int              NUM_CSR     = 16,
  parameter int              ADDR_W      = $clog2(NUM_CSR),
  parameter int              CAUSE_W     = 4,
  parameter logic [XLEN-1:0] MSTATUS_RST = XLEN'(64'hA00001800)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [XLEN-1:0]    rdata,
  input  logic               wen,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [XLEN-1:0]    wdata,
  input  logic               exception,
  input  logic [XLEN-1:0]    epc,
  input  logic [CAUSE_W-1:0] cause,
  input  logic               is_intr,
  input  logic               mret,
  input  logic               retire,
  input  logic               mtip,
  output logic               redirect_valid,
  output logic [XLEN-1:0]    redirect_pc,
  output logic               irq_pending
);

  localparam int NUM_SCR = NUM_CSR - CSR_FIRST_SCRATCH;
  localparam int SCR_N   = (NUM_SCR > 0) ? NUM_SCR : 1;

  logic [XLEN-1:0] r_mstatus, r_mtvec, r_mepc, r_mcause, r_mie, r_mip;
  logic [XLEN-1:0] r_scratch [SCR_N];
  redirect_t       r_redirect;

  logic [XLEN-1:0] w_mcycle, w_minstret, w_rdata, w_mip_nxt;
  logic w_we_mstatus, w_we_mtvec, w_we_mepc, w_we_mcause;
  logic w_we_mie, w_we_mip, w_we_mcycle, w_we_minstret;

  assign w_we_mstatus  = wen && (waddr == ADDR_W'(CSR_MSTATUS));
  assign w_we_mtvec    = wen && (waddr == ADDR_W'(CSR_MTVEC));
  assign w_we_mepc     = wen && (waddr == ADDR_W'(CSR_MEPC));
  assign w_we_mcause   = wen && (waddr == ADDR_W'(CSR_MCAUSE));
  assign w_we_mie      = wen && (waddr == ADDR_W'(CSR_MIE));
  assign w_we_mip      = wen && (waddr == ADDR_W'(CSR_MIP));
  assign w_we_mcycle   = wen && (waddr == ADDR_W'(CSR_MCYCLE));
  assign w_we_minstret = wen && (waddr == ADDR_W'(CSR_MINSTRET));

  csr_counter #(.XLEN(XLEN)) u_mcycle (
    .i_clock(clock), .i_rst_n(reset), .i_load(w_we_mcycle), .i_load_val(wdata),
    .i_inc(1'b1), .o_count(w_mcycle)
  );

  csr_counter #(.XLEN(XLEN)) u_minstret (
    .i_clock(clock), .i_rst_n(reset), .i_load(w_we_minstret), .i_load_val(wdata),
    .i_inc(retire), .o_count(w_minstret)
  );

  // software may not touch MTIP; it always tracks the sampled timer line
  always_comb begin
    w_mip_nxt = r_mip;
    if (w_we_mip) begin
      w_mip_nxt = wdata;
    end else begin
      w_mip_nxt = r_mip;
    end
    w_mip_nxt[MIP_MTIP] = mtip;
  end

  // read mux with same-cycle write forwarding
  always_comb begin
    w_rdata = '0;
    case (raddr)
      ADDR_W'(CSR_MSTATUS):  w_rdata = r_mstatus;
      ADDR_W'(CSR_MTVEC):    w_rdata = r_mtvec;
      ADDR_W'(CSR_MEPC):     w_rdata = r_mepc;
      ADDR_W'(CSR_MCAUSE):   w_rdata = r_mcause;
      ADDR_W'(CSR_MIE):      w_rdata = r_mie;
      ADDR_W'(CSR_MIP):      w_rdata = r_mip;
      ADDR_W'(CSR_MCYCLE):   w_rdata = w_mcycle;
      ADDR_W'(CSR_MINSTRET): w_rdata = w_minstret;
      default: begin
        for (int i = 0; i < NUM_SCR; i++) begin
          if (raddr == ADDR_W'(i + CSR_FIRST_SCRATCH)) begin
            w_rdata = r_scratch[i];
          end else begin
            w_rdata = w_rdata;
          end
        end
      end
    endcase
    if (wen && (waddr == raddr)) begin
      w_rdata = wdata;
    end else begin
      w_rdata = w_rdata;
    end
  end

  assign rdata = w_rdata;

  // trap-owned CSRs: exception beats mret beats software write
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_mstatus <= MSTATUS_RST;
      r_mepc    <= '0;
      r_mcause  <= '0;
    end else if (exception) begin
      r_mstatus[MSTATUS_MPIE]                  <= r_mstatus[MSTATUS_MIE];
      r_mstatus[MSTATUS_MIE]                   <= 1'b0;
      r_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] <= 2'b11;
      r_mepc   <= {epc[XLEN-1:2], 2'b00};
      r_mcause <= {is_intr, (XLEN-1)'(cause)};
    end else if (mret) begin
      r_mstatus[MSTATUS_MIE]                   <= r_mstatus[MSTATUS_MPIE];
      r_mstatus[MSTATUS_MPIE]                  <= 1'b1;
      r_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] <= 2'b11;
    end else begin
      if (w_we_mstatus) r_mstatus <= wdata;
      if (w_we_mepc)    r_mepc    <= wdata;
      if (w_we_mcause)  r_mcause  <= wdata;
    end
  end

  // remaining software-visible CSRs, unaffected by traps
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_mtvec <= '0;
      r_mie   <= '0;
      r_mip   <= '0;
      for (int i = 0; i < SCR_N; i++) r_scratch[i] <= '0;
    end else begin
      if (w_we_mtvec) r_mtvec <= wdata;
      if (w_we_mie)   r_mie   <= wdata;
      r_mip <= w_mip_nxt;
      for (int i = 0; i < NUM_SCR; i++) begin
        if (wen && (waddr == ADDR_W'(i + CSR_FIRST_SCRATCH))) r_scratch[i] <= wdata;
      end
    end
  end

  // one-cycle redirect pulse toward the IFU
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_redirect <= '0;
    end else if (exception) begin
      r_redirect.valid <= 1'b1;
      r_redirect.pc    <= REDIR_PC_W'({r_mtvec[XLEN-1:2], 2'b00});
    end else if (mret) begin
      r_redirect.valid <= 1'b1;
      r_redirect.pc    <= REDIR_PC_W'(r_mepc);
    end else begin
      r_redirect.valid <= 1'b0;
    end
  end

  assign redirect_valid = r_redirect.valid;
  assign redirect_pc    = r_redirect.pc[XLEN-1:0];
  assign irq_pending    = r_mstatus[MSTATUS_MIE] & r_mie[MIE_MTIE] & r_mip[MIP_MTIP];

endmodule

// File: tb/tb_csr_file_ext.sv
// Scoreboard bench for csr_file_ext: stimulus queues expected reads and
// redirects; a negedge monitor pops and compares them against the DUT.
module tb_csr_file_ext;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  raddr, waddr;
  logic [63:0] rdata, wdata, epc, redirect_pc;
  logic        wen, exception, is_intr, mret, retire, mtip;
  logic [3:0]  cause;
  logic        redirect_valid, irq_pending;
  logic        done = 1'b0;

  typedef struct {
    string       name;
    int          sel;
    logic [63:0] exp;
  } chk_t;

  chk_t        rd_q[$];
  logic [63:0] rq[$];
  int          n_vec = 0;
  int          n_bad = 0;

  csr_file_ext dut (
    .clock(clock), .reset(reset), .raddr(raddr), .rdata(rdata),
    .wen(wen), .waddr(waddr), .wdata(wdata),
    .exception(exception), .epc(epc), .cause(cause), .is_intr(is_intr),
    .mret(mret), .retire(retire), .mtip(mtip),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .irq_pending(irq_pending)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
    wen = 1'b0; exception = 1'b0; mret = 1'b0; retire = 1'b0; is_intr = 1'b0;
  endtask

  task automatic exp_rd(input logic [3:0] a, input logic [63:0] v, input string n);
    raddr = a;
    rd_q.push_back('{name: n, sel: 0, exp: v});
  endtask

  task automatic exp_sig(input int s, input logic v, input string n);
    rd_q.push_back('{name: n, sel: s, exp: {63'd0, v}});
  endtask

  task automatic wr(input logic [3:0] a, input logic [63:0] d);
    wen = 1'b1; waddr = a; wdata = d;
  endtask

  task automatic trap(input logic [63:0] pc, input logic [3:0] c, input logic intr);
    exception = 1'b1; epc = pc; cause = c; is_intr = intr;
  endtask

  // monitor: compares every queued expectation and every redirect pulse
  initial begin
    chk_t        c;
    logic [63:0] act, e;
    forever begin
      @(negedge clock);
      while (rd_q.size() > 0) begin
        c = rd_q.pop_front();
        case (c.sel)
          0:       act = rdata;
          1:       act = {63'd0, redirect_valid};
          default: act = {63'd0, irq_pending};
        endcase
        n_vec++;
        if (act !== c.exp) begin
          n_bad++;
          $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
        end
      end
      if (redirect_valid) begin
        n_vec++;
        if (rq.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_redirect: got pc %h expected no redirect", redirect_pc);
        end else begin
          e = rq.pop_front();
          if (redirect_pc !== e) begin
            n_bad++;
            $display("FAIL redirect_pc: got %h expected %h", redirect_pc, e);
          end
        end
      end
      if (done) begin
        n_vec++;
        if (rq.size() != 0) begin
          n_bad++;
          $display("FAIL missing_redirects: got %0d unseen expected 0", rq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
      end
    end
  end

  initial begin
    reset = 1'b0; raddr = 4'd0; waddr = 4'd0; wdata = 64'd0; wen = 1'b0;
    exception = 1'b0; epc = 64'd0; cause = 4'd0; is_intr = 1'b0;
    mret = 1'b0; retire = 1'b0; mtip = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    // reset values and free-running mcycle
    exp_rd(4'd6, 64'd0, "mcycle_c0"); exp_sig(1, 1'b0, "redir_idle"); cyc();
    exp_rd(4'd6, 64'd1, "mcycle_c1"); cyc();
    exp_rd(4'd6, 64'd2, "mcycle_c2"); cyc();
    exp_rd(4'd0, 64'hA00001800, "mstatus_rst"); cyc();

    // mtvec write forwarded, then a synchronous trap
    wr(4'd1, 64'h8000_0103); exp_rd(4'd1, 64'h8000_0103, "mtvec_fwd"); cyc();
    trap(64'h8000_0042, 4'd11, 1'b0); rq.push_back(64'h8000_0100);
    exp_rd(4'd1, 64'h8000_0103, "mtvec_reg"); cyc();
    exp_rd(4'd2, 64'h8000_0040, "mepc_align"); cyc();
    exp_rd(4'd3, 64'd11, "mcause_sync"); exp_sig(1, 1'b0, "redir_pulse_end"); cyc();

    // interrupt trap with MIE set, then mret
    wr(4'd0, 64'hA00001808); exp_rd(4'd0, 64'hA00001808, "mstatus_fwd"); cyc();
    trap(64'h8000_0200, 4'd7, 1'b1); rq.push_back(64'h8000_0100);
    exp_rd(4'd0, 64'hA00001808, "mstatus_pre_trap"); cyc();
    exp_rd(4'd0, 64'hA00001880, "mstatus_trap"); cyc();
    exp_rd(4'd3, 64'h8000_0000_0000_0007, "mcause_intr"); cyc();
    mret = 1'b1; rq.push_back(64'h8000_0200);
    exp_rd(4'd2, 64'h8000_0200, "mepc_intr"); cyc();
    exp_rd(4'd0, 64'hA00001888, "mstatus_mret"); cyc();

    // back-to-back traps, then exception+mret+mepc write on one edge
    trap(64'h3003, 4'd2, 1'b0); rq.push_back(64'h8000_0100); cyc();
    trap(64'h4000, 4'd3, 1'b0); rq.push_back(64'h8000_0100); cyc();
    trap(64'h5556, 4'd1, 1'b0); mret = 1'b1; wr(4'd2, 64'h1234);
    rq.push_back(64'h8000_0100); cyc();
    exp_rd(4'd2, 64'h5554, "mepc_priority"); cyc();
    exp_rd(4'd3, 64'd1, "mcause_priority"); exp_sig(1, 1'b0, "redir_single"); cyc();
    exp_rd(4'd0, 64'hA00001800, "mstatus_b2b"); cyc();

    // scratch write completes during a trap
    trap(64'h6000, 4'd4, 1'b0); wr(4'd8, 64'hBEEF); rq.push_back(64'h8000_0100); cyc();
    exp_rd(4'd8, 64'hBEEF, "scratch_in_trap"); cyc();

    // timer interrupt path and MTIP write protection
    wr(4'd4, 64'h80); cyc();
    wr(4'd0, 64'hA00001808); exp_sig(2, 1'b0, "irq_no_mtip"); cyc();
    mtip = 1'b1; exp_sig(2, 1'b0, "irq_mtip_lag"); cyc();
    exp_sig(2, 1'b1, "irq_set"); wr(4'd5, 64'd0); exp_rd(4'd5, 64'd0, "mip_fwd"); cyc();
    exp_rd(4'd5, 64'h80, "mip_mtip_kept"); exp_sig(2, 1'b1, "irq_held"); mtip = 1'b0; cyc();
    exp_rd(4'd5, 64'd0, "mip_mtip_clr"); exp_sig(2, 1'b0, "irq_clr"); cyc();

    // minstret wrap and write-over-retire priority
    wr(4'd7, 64'hFFFF_FFFF_FFFF_FFFF); cyc();
    retire = 1'b1; exp_rd(4'd7, 64'hFFFF_FFFF_FFFF_FFFF, "minstret_ones"); cyc();
    retire = 1'b1; exp_rd(4'd7, 64'd0, "minstret_wrap"); cyc();
    retire = 1'b1; wr(4'd7, 64'h55); exp_rd(4'd0, 64'hA00001808, "mstatus_hold"); cyc();
    exp_rd(4'd7, 64'h55, "minstret_wr_wins"); cyc();

    // mcycle load suppresses that cycle's increment
    wr(4'd6, 64'd100); cyc();
    exp_rd(4'd6, 64'd100, "mcycle_load"); cyc();
    exp_rd(4'd6, 64'd101, "mcycle_after_load"); cyc();

    // reset asserted while a redirect pulse is live
    trap(64'h7000, 4'd5, 1'b0); cyc();
    reset = 1'b0;
    exp_sig(1, 1'b0, "redir_reset_kill"); exp_rd(4'd0, 64'hA00001800, "mstatus_rereset"); cyc();
    reset = 1'b1;
    exp_rd(4'd2, 64'd0, "mepc_rereset"); cyc();
    cyc();
    done = 1'b1;
    repeat (5) @(posedge clock);
    $display("FAIL monitor_timeout: got no summary expected summary");
    $fatal(1);
  end

endmodule
